// File: rtl/vga_sink_monitor_if.sv
// ---------------------------------------------------------------------------
// vga_sink_monitor_if
// Bundles the two buses seen by the VGA sink monitor:
//   - VGA stream: vga_clk, vga_hs, vga_vs, vga_blank_n, vga_r/g/b
//   - Avalon-MM slave: chipselect, read, write, address[3:0], writedata[15:0],
//     readdata[15:0], plus the level end-of-frame interrupt irq.
// Modports:
//   master - the side that produces the video and issues bus cycles
//   slave  - the monitor itself
// ---------------------------------------------------------------------------
interface vga_sink_monitor_if;
    logic        vga_clk;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [3:0]  address;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (
        output vga_clk, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b,
        output chipselect, read, write, address, writedata,
        input  readdata, irq
    );

    modport slave (
        input  vga_clk, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b,
        input  chipselect, read, write, address, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/vga_sink_monitor.sv
// ---------------------------------------------------------------------------
// vga_sink_monitor
// Receive-side checker for the VGA stream from the team's generator. Recovers
// pixel coordinates from HS/VS/BLANK_n/VGA_CLK, measures frame geometry,
// declares lock after two consecutive good frames, captures one programmable
// pixel and exposes everything through a small Avalon-MM register file.
//
// Ports:
//   clk    - system clock (same domain as the generator)
//   reset  - asynchronous, active-high
//   bus    - vga_sink_monitor_if.slave (VGA inputs, Avalon-MM slave, irq)
//
// Register map (address: write / read):
//   0 CTRL : w {bit0 irq_en, bit1 clear eof_pend and err}
//            r {13'b0, err, cap_valid, locked}
//   1 CAP_X rw, 2 CAP_Y rw, 3 r {R,G}, 4 r {8'h00,B},
//   5 r meas_w, 6 r meas_h, 7 r frame_cnt, 8 r frame CRC, others read 0.
//
// Build option: define VGA_SINK_CRC_EN to add a CRC-16-CCITT over the RGB
// of every active pixel, latched into register 8 at each VS falling edge.
// Without it register 8 reads 0x0000 and no CRC logic exists.
// ---------------------------------------------------------------------------
module vga_sink_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525
) (
    input  logic              clk,
    input  logic              reset,
    vga_sink_monitor_if.slave bus
);
    localparam logic [9:0] H_ACTIVE_W = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACTIVE_W = 10'(V_ACTIVE);
    localparam logic [9:0] H_TOTAL_W  = 10'(H_TOTAL);
    localparam logic [9:0] V_TOTAL_W  = 10'(V_TOTAL);

    typedef enum logic [1:0] {WAIT_VS, MEASURE, LOCKED} state_t;

    // ------------------------------------------------------------------
    // Input stage: every VGA input registered once
    // ------------------------------------------------------------------
    logic       vga_clk_reg, vga_clk_prev_reg;
    logic       hs_reg, vs_reg, blank_reg;
    logic       hs_last_reg, vs_last_reg;
    logic [7:0] rgb_in      [3];
    logic [7:0] rgb_reg     [3];
    logic [7:0] cap_rgb_reg [3];

    assign rgb_in[0] = bus.vga_r;
    assign rgb_in[1] = bus.vga_g;
    assign rgb_in[2] = bus.vga_b;

    logic pix_stb, hs_fall, vs_fall, active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_clk_reg      <= 1'b0;
            vga_clk_prev_reg <= 1'b0;
            hs_reg           <= 1'b0;
            vs_reg           <= 1'b0;
            blank_reg        <= 1'b0;
            hs_last_reg      <= 1'b0;
            vs_last_reg      <= 1'b0;
        end else begin
            vga_clk_reg      <= bus.vga_clk;
            vga_clk_prev_reg <= vga_clk_reg;
            hs_reg           <= bus.vga_hs;
            vs_reg           <= bus.vga_vs;
            blank_reg        <= bus.vga_blank_n;
            // Sync history is sampled per pixel so edges line up with strobes.
            if (pix_stb) begin
                hs_last_reg <= hs_reg;
                vs_last_reg <= vs_reg;
            end
        end
    end

    // History resets low, so a reset release can never fake a falling edge.
    assign pix_stb = vga_clk_reg & ~vga_clk_prev_reg;
    assign hs_fall = pix_stb & hs_last_reg & ~hs_reg;
    assign vs_fall = pix_stb & vs_last_reg & ~vs_reg;
    assign active  = pix_stb & blank_reg;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic rd_en, wr_en, ctrl_wr, ctrl_clr, capture;
    logic [9:0] x_reg, y_reg, cap_x_reg, cap_y_reg;

    assign rd_en    = bus.chipselect & bus.read;
    assign wr_en    = bus.chipselect & bus.write;
    assign ctrl_wr  = wr_en && (bus.address == 4'd0);
    assign ctrl_clr = ctrl_wr & bus.writedata[1];
    assign capture  = active && (x_reg == cap_x_reg) && (y_reg == cap_y_reg);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rgb_reg[gi]     <= 8'h00;
                    cap_rgb_reg[gi] <= 8'h00;
                end else begin
                    rgb_reg[gi] <= rgb_in[gi];
                    if (capture)
                        cap_rgb_reg[gi] <= rgb_reg[gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Timing counters and frame measurements
    // ------------------------------------------------------------------
    logic [9:0]  hcnt_reg, vcnt_reg, x_max_reg;
    logic [9:0]  meas_w_reg, meas_h_reg;
    logic [15:0] frame_cnt_reg;
    logic        htot_bad_reg;

    logic [9:0] hcnt_inc, x_next, x_max_next, y_next, vcnt_next;
    logic       htot_bad_next, frame_match;

    always_comb begin
        // The strobe that carries the HS fall closes the line, so it is
        // counted into this line's total before the clear.
        hcnt_inc   = hcnt_reg + 10'd1;
        x_next     = (active && (x_reg != 10'h3FF)) ? x_reg + 10'd1 : x_reg;
        x_max_next = (x_next > x_max_reg) ? x_next : x_max_reg;
        y_next     = (hs_fall && (x_next != 10'd0)) ? y_reg + 10'd1 : y_reg;
        vcnt_next  = hs_fall ? vcnt_reg + 10'd1 : vcnt_reg;
        htot_bad_next = htot_bad_reg | (hs_fall && (hcnt_inc != H_TOTAL_W));
        frame_match   = (x_max_next == H_ACTIVE_W) && (y_next == V_ACTIVE_W) &&
                        (vcnt_next == V_TOTAL_W) && !htot_bad_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_reg      <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            vcnt_reg      <= '0;
            x_max_reg     <= '0;
            htot_bad_reg  <= 1'b0;
            meas_w_reg    <= '0;
            meas_h_reg    <= '0;
            frame_cnt_reg <= '0;
        end else if (pix_stb) begin
            hcnt_reg <= hs_fall ? '0 : hcnt_inc;
            x_reg    <= hs_fall ? '0 : x_next;
            if (vs_fall) begin
                meas_w_reg    <= x_max_next;
                meas_h_reg    <= y_next;
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
                y_reg         <= '0;
                vcnt_reg      <= '0;
                x_max_reg     <= '0;
                htot_bad_reg  <= 1'b0;
            end else begin
                y_reg        <= y_next;
                vcnt_reg     <= vcnt_next;
                x_max_reg    <= x_max_next;
                htot_bad_reg <= htot_bad_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM. match_one_reg remembers one good frame while measuring.
    // ------------------------------------------------------------------
    state_t state_reg;
    logic   match_one_reg, err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= WAIT_VS;
            match_one_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            if (vs_fall) begin
                case (state_reg)
                    WAIT_VS: begin
                        // Whatever preceded this edge is a partial frame.
                        state_reg     <= MEASURE;
                        match_one_reg <= 1'b0;
                    end
                    MEASURE: begin
                        if (frame_match && match_one_reg) begin
                            state_reg     <= LOCKED;
                            match_one_reg <= 1'b0;
                        end else begin
                            match_one_reg <= frame_match;
                        end
                    end
                    LOCKED: begin
                        if (!frame_match) begin
                            state_reg     <= MEASURE;
                            match_one_reg <= 1'b0;
                        end
                    end
                    default: state_reg <= WAIT_VS;
                endcase
            end
            // A fresh loss of lock outranks a simultaneous software clear.
            if (vs_fall && (state_reg == LOCKED) && !frame_match)
                err_reg <= 1'b1;
            else if (ctrl_clr)
                err_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Optional frame CRC
    // ------------------------------------------------------------------
    logic [15:0] crc_value;

`ifdef VGA_SINK_CRC_EN
    logic [15:0] crc_run_reg, crc_value_reg, crc_run_next;

    function automatic logic [15:0] crc_step(input logic [15:0] crc_in,
                                             input logic [23:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 23; i >= 0; i--) begin
            if (c[15] ^ data[i])
                c = {c[14:0], 1'b0} ^ 16'h1021;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    always_comb begin
        crc_run_next = crc_run_reg;
        if (active)
            crc_run_next = crc_step(crc_run_reg, {rgb_reg[0], rgb_reg[1], rgb_reg[2]});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_run_reg   <= 16'hFFFF;
            crc_value_reg <= 16'h0000;
        end else if (vs_fall) begin
            crc_value_reg <= crc_run_next;
            crc_run_reg   <= 16'hFFFF;
        end else begin
            crc_run_reg <= crc_run_next;
        end
    end

    assign crc_value = crc_value_reg;
`else
    assign crc_value = 16'h0000;
`endif

    // ------------------------------------------------------------------
    // Register file, capture flag and interrupt
    // ------------------------------------------------------------------
    logic        irq_en_reg, eof_pend_reg, irq_reg, cap_valid_reg;
    logic        irq_en_next, eof_pend_next;
    logic [15:0] readdata_reg, read_mux;
    logic        unused_wdata;

    assign unused_wdata = ^bus.writedata[15:10];

    always_comb begin
        irq_en_next   = ctrl_wr ? bus.writedata[0] : irq_en_reg;
        // A new frame end is never lost to a clear in the same cycle.
        eof_pend_next = vs_fall ? 1'b1 : (ctrl_clr ? 1'b0 : eof_pend_reg);
    end

    always_comb begin
        read_mux = 16'h0000;
        case (bus.address)
            4'd0: read_mux = {13'b0, err_reg, cap_valid_reg, state_reg == LOCKED};
            4'd1: read_mux = {6'b0, cap_x_reg};
            4'd2: read_mux = {6'b0, cap_y_reg};
            4'd3: read_mux = {cap_rgb_reg[0], cap_rgb_reg[1]};
            4'd4: read_mux = {8'h00, cap_rgb_reg[2]};
            4'd5: read_mux = {6'b0, meas_w_reg};
            4'd6: read_mux = {6'b0, meas_h_reg};
            4'd7: read_mux = frame_cnt_reg;
            4'd8: read_mux = crc_value;
            default: read_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_reg    <= 1'b0;
            eof_pend_reg  <= 1'b0;
            irq_reg       <= 1'b0;
            cap_valid_reg <= 1'b0;
            cap_x_reg     <= '0;
            cap_y_reg     <= '0;
            readdata_reg  <= '0;
        end else begin
            irq_en_reg   <= irq_en_next;
            eof_pend_reg <= eof_pend_next;
            irq_reg      <= irq_en_next & eof_pend_next;
            if (wr_en && (bus.address == 4'd1))
                cap_x_reg <= bus.writedata[9:0];
            if (wr_en && (bus.address == 4'd2))
                cap_y_reg <= bus.writedata[9:0];
            if (rd_en)
                readdata_reg <= read_mux;
            // Capture beats the read-clear of register 3 in the same cycle.
            if (capture)
                cap_valid_reg <= 1'b1;
            else if (rd_en && (bus.address == 4'd3))
                cap_valid_reg <= 1'b0;
        end
    end

    assign bus.readdata = readdata_reg;
    assign bus.irq      = irq_reg;

endmodule

// File: tb/tb_vga_sink_monitor.sv
// ---------------------------------------------------------------------------
// tb_vga_sink_monitor
// Directed bench for vga_sink_monitor using a scaled-down raster
// (16x8 active, 24 pixels per line, 12 lines per frame) so that many frames
// fit in a short run. The bench generates the VGA stream and the Avalon
// cycles itself; expected values are worked out by hand from the raster.
// ---------------------------------------------------------------------------
module tb_vga_sink_monitor;
    localparam int H_ACT    = 16;
    localparam int H_TOT    = 24;
    localparam int V_ACT    = 8;
    localparam int V_TOT    = 12;
    localparam int HS_START = 18;
    localparam int HS_END   = 21;
    localparam int VS_START = 9;
    localparam int VS_END   = 11;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    vga_sink_monitor_if bus();

    vga_sink_monitor #(
        .H_ACTIVE (H_ACT),
        .V_ACTIVE (V_ACT),
        .H_TOTAL  (H_TOT),
        .V_TOTAL  (V_TOT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          ball_on = 1'b0;
    int          ball_x = 0;
    int          ball_y = 0;
    logic [7:0]  colour_b = 8'h80;
    logic [15:0] tb_crc = 16'hFFFF;
    logic [15:0] exp_crc = 16'h0000;
    logic [15:0] rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %-16s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("pass %-16s value=0x%0h", tag, got);
        end
    endtask

    // Reference CRC-16-CCITT, one data bit at a time, MSB first.
    function automatic logic [15:0] ref_crc(input logic [15:0] crc_in, input logic [23:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 23; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = c << 1;
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // One pixel = two system clocks: vga_clk low, then high.
    task automatic send_px(input int px, input int line, input bit drop_hs);
        bit          act;
        logic [23:0] rgb;
        act = (px < H_ACT) && (line < V_ACT);
        if (!act)
            rgb = 24'h000000;
        else if (ball_on && px == ball_x && line == ball_y)
            rgb = 24'hFFFFFF;
        else
            rgb = {8'h80, 8'h00, colour_b};
        if (line == VS_START && px == 0) begin
            exp_crc = tb_crc;
            tb_crc  = 16'hFFFF;
        end
        if (act) tb_crc = ref_crc(tb_crc, rgb);
        bus.vga_clk     = 1'b0;
        bus.vga_hs      = (!drop_hs && px >= HS_START && px < HS_END) ? 1'b0 : 1'b1;
        bus.vga_vs      = (line >= VS_START && line < VS_END) ? 1'b0 : 1'b1;
        bus.vga_blank_n = act;
        bus.vga_r       = rgb[23:16];
        bus.vga_g       = rgb[15:8];
        bus.vga_b       = rgb[7:0];
        @(negedge clk);
        bus.vga_clk = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_line(input int line, input bit drop_hs);
        for (int px = 0; px < H_TOT; px++) send_px(px, line, drop_hs);
    endtask

    task automatic send_frame(input int drop_line);
        for (int line = 0; line < V_TOT; line++) send_line(line, line == drop_line);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d, input bit cs);
        bus.chipselect = cs;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        d = bus.readdata;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.vga_clk = 1'b0; bus.vga_hs = 1'b1; bus.vga_vs = 1'b1; bus.vga_blank_n = 1'b0;
        bus.vga_r = 8'h00; bus.vga_g = 8'h00; bus.vga_b = 8'h00;
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.address = 4'd0; bus.writedata = 16'h0000;

        repeat (3) @(negedge clk);
        check("rst_readdata", bus.readdata, 16'h0000);
        check("rst_irq", bus.irq, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        bus_read(4'd0, rd); check("rst_ctrl", rd, 16'h0000);
        bus_read(4'd7, rd); check("rst_frame_cnt", rd, 16'h0000);

        // Nominal frames: lock needs the first VS edge plus two good frames.
        send_frame(-1);
        send_frame(-1);
        bus_read(4'd0, rd); check("ctrl_2_frames", rd, 16'h0002);
        send_frame(-1);
        bus_read(4'd0, rd); check("ctrl_locked", rd, 16'h0003);
        bus_read(4'd5, rd); check("meas_w", rd, 16'd16);
        bus_read(4'd6, rd); check("meas_h", rd, 16'd8);
        bus_read(4'd7, rd); check("frame_cnt_3", rd, 16'd3);
        bus_read(4'd3, rd); check("cap_rg_solid", rd, 16'h8000);
        bus_read(4'd4, rd); check("cap_b_solid", rd, 16'h0080);
        check("irq_masked", bus.irq, 1'b0);
`ifdef VGA_SINK_CRC_EN
        bus_read(4'd8, rd); check("crc_frame", rd, exp_crc);
`else
        bus_read(4'd8, rd); check("reg8_no_crc", rd, 16'h0000);
`endif

        // Capture point and a white ball drawn there.
        bus_write(4'd1, 16'd7, 1'b0);
        bus_read(4'd1, rd); check("cs0_ignored", rd, 16'd0);
        bus_write(4'd1, 16'd10, 1'b1);
        bus_write(4'd2, 16'd5, 1'b1);
        bus_read(4'd2, rd); check("cap_y_rb", rd, 16'd5);
        ball_on = 1'b1; ball_x = 10; ball_y = 5;
        send_frame(-1);
        bus_read(4'd0, rd); check("ctrl_capvalid", rd, 16'h0003);
        bus_read(4'd3, rd); check("cap_rg_ball", rd, 16'hFFFF);
        bus_read(4'd4, rd); check("cap_b_ball", rd, 16'h00FF);
        bus_read(4'd0, rd); check("ctrl_cap_clr", rd, 16'h0001);

        // Missing HS pulse while locked.
        send_frame(3);
        bus_read(4'd0, rd); check("ctrl_after_drop", rd, 16'h0006);
        send_frame(-1);
        send_frame(-1);
        bus_read(4'd0, rd); check("ctrl_relock", rd, 16'h0007);
        bus_write(4'd0, 16'h0002, 1'b1);
        bus_read(4'd0, rd); check("ctrl_err_clr", rd, 16'h0003);

        // End-of-frame interrupt timing.
        bus_write(4'd0, 16'h0003, 1'b1);
        check("irq_after_clr", bus.irq, 1'b0);
        for (int line = 0; line < VS_START; line++) send_line(line, 1'b0);
        send_px(0, VS_START, 1'b0);
        check("irq_at_vs_edge", bus.irq, 1'b0);
        @(posedge clk); #1;
        check("irq_rises", bus.irq, 1'b1);
        @(negedge clk);
        for (int px = 1; px < H_TOT; px++) send_px(px, VS_START, 1'b0);
        for (int line = VS_START + 1; line < V_TOT; line++) send_line(line, 1'b0);
        bus_write(4'd0, 16'h0003, 1'b1);
        check("irq_cleared", bus.irq, 1'b0);
        send_frame(-1);
        check("irq_still_en", bus.irq, 1'b1);
        bus_read(4'd7, rd); check("frame_cnt_9", rd, 16'd9);

        // Asynchronous reset in the middle of line 5.
        for (int line = 0; line < 5; line++) send_line(line, 1'b0);
        for (int px = 0; px <= 10; px++) send_px(px, 5, 1'b0);
        #3 reset = 1'b1;
        #1;
        check("midrst_readdata", bus.readdata, 16'h0000);
        check("midrst_irq", bus.irq, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        tb_crc = 16'hFFFF;
        bus_read(4'd0, rd); check("midrst_ctrl", rd, 16'h0000);
        bus_read(4'd5, rd); check("midrst_meas_w", rd, 16'h0000);
        for (int px = 11; px < H_TOT; px++) send_px(px, 5, 1'b0);
        for (int line = 6; line < V_TOT; line++) send_line(line, 1'b0);
        send_frame(-1);
        bus_read(4'd0, rd); check("midrst_2_vs", rd, 16'h0002);
        send_frame(-1);
        bus_read(4'd0, rd); check("midrst_relock", rd, 16'h0003);

`ifdef VGA_SINK_CRC_EN
        colour_b = 8'h40;
        send_frame(-1);
        send_frame(-1);
        bus_read(4'd8, rd); check("crc_new_colour", rd, exp_crc);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
